// File: rtl/loader_pkg.sv
// Shared definitions for the front-panel memory loader: FSM encodings,
// key bit positions and the word shown after a read timeout.
package loader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_READ  = 2'd2;
    localparam state_t ST_RUN   = 2'd3;

    localparam int KEY_ADDR = 0;
    localparam int KEY_WR   = 1;
    localparam int KEY_RD   = 2;
    localparam int KEY_RUN  = 3;

    localparam logic [15:0] ERR_WORD = 16'hDEAD;

endpackage

// File: rtl/key_edge_sync.sv
// Synchronizes one raw active-low push key and emits a registered
// single-cycle pulse on each press (falling edge of the synchronized level).
module key_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   press_q;

    // Flops reset low so the idle-high keys rise after reset and never look like a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            press_q <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mem_load_ctrl.sv
// Front-panel loader for the main memory: set address, write/read with post-increment, hand-off to CPU.
// Define LOAD_CHECKSUM_EN to build the running checksum of written words; otherwise Checksum is 0.
module mem_load_ctrl
    import loader_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] SW,
    input  logic [3:0]        Key,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWE,
    output logic              MemRE,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemValid,
    output logic              CpuGrant,
    output logic              Busy,
    output logic              Err,
    output logic [DATA_W-1:0] DispWord,
    output logic              DispSel,
    output logic [ADDR_W-1:0] WordCount,
    output logic [DATA_W-1:0] Checksum
);

    localparam int TO_W = $clog2(RD_TIMEOUT + 1);

    logic [3:0] press;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i   (Clock),
            .rst_ni  (Reset_n),
            .key_i   (Key[gi]),
            .press_o (press[gi])
        );
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TO_W-1:0]     age_q, age_d;
    logic [DATA_W-1:0]   disp_q, disp_d;
    logic                sel_q, sel_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        age_d   = age_q;
        disp_d  = disp_q;
        sel_d   = sel_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                // Only the highest-priority pulse of a cycle acts; the rest are dropped.
                if (press[KEY_RUN]) begin
                    state_d = ST_RUN;
                end else if (press[KEY_ADDR]) begin
                    addr_d = ADDR_W'(SW);
                    disp_d = SW;
                    sel_d  = 1'b0;
                    err_d  = 1'b0;
                end else if (press[KEY_WR]) begin
                    state_d = ST_WRITE;
                end else if (press[KEY_RD]) begin
                    state_d = ST_READ;
                    age_d   = '0;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                wcnt_d  = (&wcnt_q) ? wcnt_q : wcnt_q + ADDR_W'(1);
                state_d = ST_IDLE;
            end
            ST_READ: begin
                if (MemValid) begin
                    disp_d  = MemRData;
                    sel_d   = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_IDLE;
                end else if (age_q == TO_W'(RD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    disp_d  = DATA_W'(ERR_WORD);
                    state_d = ST_IDLE;
                end else begin
                    age_d = age_q + TO_W'(1);
                end
            end
            ST_RUN: begin
                if (press[KEY_RUN]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            age_q   <= '0;
            disp_q  <= '0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            age_q   <= age_d;
            disp_q  <= disp_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            csum_q <= '0;
        end else if (state_q == ST_WRITE) begin
            csum_q <= csum_q + SW;
        end
    end

    assign Checksum = csum_q;
`else
    assign Checksum = '0;
`endif

    // Strobes decode straight from state, so an async reset clears them immediately.
    assign MemWE     = (state_q == ST_WRITE);
    assign MemRE     = (state_q == ST_READ) && (age_q == '0);
    assign Busy      = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign CpuGrant  = (state_q == ST_RUN);
    assign MemAddr   = Busy ? addr_q : '0;
    assign MemWData  = MemWE ? SW : '0;
    assign Err       = err_q;
    assign DispWord  = disp_q;
    assign DispSel   = sel_q;
    assign WordCount = wcnt_q;

endmodule
